// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, state encoding and row-vector type for the systolic result path
package systolic_pkg;

  localparam int N      = 8;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;

  localparam int ROW_W  = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W  = (N * N > 1) ? $clog2(N * N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Element c of a row vector is column c of the matrix.
  typedef logic [0:N-1][DATA_W-1:0] row_t;

endpackage

// File: rtl/drain_buf.sv
// rtl/drain_buf.sv - N x N result storage, one row written per beat, one word read by linear index
module drain_buf
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  row_t              wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  // Stored in load order: linear index = row * N + col.
  logic [DATA_W-1:0] mem [0:N*N-1];

  // Row write: all N columns of one row land in a single cycle; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem[IDX_W'(int'(wr_row) * N + c)] <= wr_data[c];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rf_drain.sv
// rtl/rf_drain.sv - capture an N x N result matrix row by row and drain it as an addressed word stream
module rf_drain
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              res_valid,
  input  row_t              res_in,
  output logic              res_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

  state_t              state, state_n;
  logic [ROW_W-1:0]    row_cnt;
  logic [IDX_W-1:0]    idx;
  logic [ADDR_W-1:0]   base;
  logic                done_q;
  logic                ovf_q;
  logic                buf_we;
  logic [ROW_W-1:0]    buf_row;
  logic [DATA_W-1:0]   buf_word;
  logic                final_hs;

  drain_buf u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_row  (buf_row),
    .wr_data (res_in),
    .rd_idx  (idx),
    .rd_data (buf_word)
  );

  // The final word handshake ends the drain; DONE follows it by one cycle.
  assign final_hs = (state == ST_DRAIN) && out_ready && (idx == LAST_IDX);

  // Next-state and buffer write decode; the first beat always lands in row 0.
  always_comb begin
    state_n = state;
    buf_we  = 1'b0;
    buf_row = row_cnt;
    case (state)
      ST_IDLE: begin
        buf_row = '0;
        if (res_valid) begin
          buf_we  = 1'b1;
          state_n = (N == 1) ? ST_DRAIN : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (res_valid) begin
          buf_we = 1'b1;
          if (row_cnt == LAST_ROW) begin
            state_n = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (final_hs) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, row/word counters, latched base address and the DONE/OVF flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      row_cnt <= '0;
      idx     <= '0;
      base    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= final_hs;
      case (state)
        ST_IDLE: begin
          if (res_valid) begin
            base    <= base_addr;
            row_cnt <= (N == 1) ? '0 : ROW_W'(1);
            idx     <= '0;
            ovf_q   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (res_valid) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              idx     <= '0;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (res_valid) begin
            ovf_q <= 1'b1;
          end
          if (out_ready) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_ready = (state != ST_DRAIN);
  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign ovf       = ovf_q;
  // Outputs are forced to zero outside DRAIN so the unreset buffer never shows through.
  assign out_addr  = out_valid ? base + ADDR_W'(idx) : '0;
  assign out_data  = out_valid ? buf_word : '0;
  assign out_last  = out_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_rf_drain.sv
// tb/tb_rf_drain.sv - randomized scoreboard bench for rf_drain
module tb_rf_drain;
  import systolic_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] base_addr;
  logic              res_valid;
  row_t              res_in;
  logic              res_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              ovf;

  rf_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_addr (base_addr),
    .res_valid (res_valid),
    .res_in    (res_in),
    .res_ready (res_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  word_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    accepted = 0;
  bit    rand_ready = 0;

  bit                prev_final = 0;
  bit                stall_held = 0;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;
  logic              held_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: steady high or a coin flip every cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expected words on handshakes, checks stall stability and DONE timing.
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      prev_final = 0;
      stall_held = 0;
    end else begin
      chk("done_pulse", done, prev_final);
      prev_final = 0;
      if (stall_held && out_valid) begin
        chk("stall_addr", out_addr, held_addr);
        chk("stall_data", out_data, held_data);
        chk("stall_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        stall_held = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("word_addr", out_addr, w.addr);
          chk("word_data", out_data, w.data);
          chk("word_last", out_last, w.last);
          prev_final = w.last;
        end
        accepted++;
      end else if (out_valid) begin
        stall_held = 1;
        held_addr  = out_addr;
        held_data  = out_data;
        held_last  = out_last;
      end else begin
        stall_held = 0;
      end
    end
  end

  // Drive one matrix (kind 0: r*8+c, else random); expected stream queued up front.
  task automatic send_matrix(input logic [ADDR_W-1:0] b, input int kind, input int gap_pct);
    logic [DATA_W-1:0] m [0:N-1][0:N-1];
    word_t w;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = (kind == 0) ? DATA_W'(r * 8 + c) : DATA_W'($urandom);
    for (int i = 0; i < N * N; i++) begin
      w.addr = b + ADDR_W'(i);
      w.data = m[i / N][i % N];
      w.last = (i == N * N - 1);
      exp_q.push_back(w);
    end
    for (int r = 0; r < N; r++) begin
      while (r > 0 && $urandom_range(0, 99) < gap_pct) begin
        res_valid = 1'b0;
        res_in    = row_t'({$urandom, $urandom, $urandom, $urandom});
        @(posedge clk);
        #1;
      end
      chk("capture_ready", res_ready, 1);
      res_valid = 1'b1;
      base_addr = (r == 0) ? b : $urandom;
      for (int c = 0; c < N; c++) res_in[c] = m[r][c];
      @(posedge clk);
      #1;
      if (r == 0) begin
        chk("ovf_cleared", ovf, 0);
        chk("busy_capture", busy, 1);
      end
    end
    res_valid = 1'b0;
    chk("latency_valid", out_valid, 1);
    chk("latency_first_addr", out_addr, b);
    chk("drain_not_ready", res_ready, 0);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_in    = '0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_res_ready", res_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;

    // Ramp pattern, steady ready.
    rand_ready = 0;
    send_matrix(32'h100, 0, 0);
    wait_drain("drain1_timeout");

    // Same matrix with stalls and capture gaps.
    rand_ready = 1;
    send_matrix(32'h100, 0, 30);
    wait_drain("drain2_timeout");

    // Overflow: a row offered during drain is dropped and flagged.
    send_matrix($urandom, 1, 20);
    chk("ovf_pre", ovf, 0);
    res_valid = 1'b1;
    res_in    = row_t'({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    chk("ovf_set", ovf, 1);
    wait_drain("drain3_timeout");
    chk("ovf_sticky", ovf, 1);

    // Address wrap across 2^32.
    rand_ready = 0;
    send_matrix(32'hFFFF_FFF8, 1, 0);
    wait_drain("drain4_timeout");

    // Reset at drain word 20, then a clean matrix.
    begin
      bit hit = 0;
      accepted = 0;
      send_matrix($urandom, 1, 0);
      for (int k = 0; k < 500; k++) begin
        if (accepted >= 20) begin
          hit = 1;
          break;
        end
        @(posedge clk);
        #1;
      end
      chk("reach_word20", hit, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("postrst_ready", res_ready, 1);
      chk("postrst_done", done, 0);
      send_matrix(32'h2000, 1, 10);
      wait_drain("drain5_timeout");
    end

    // Back-to-back: second matrix starts in the DONE cycle.
    begin
      bit seen = 0;
      rand_ready = 1;
      send_matrix($urandom, 1, 0);
      for (int k = 0; k < 3000; k++) begin
        @(posedge clk);
        #1;
        if (done) begin
          seen = 1;
          break;
        end
      end
      chk("b2b_done_seen", seen, 1);
      chk("b2b_ready_with_done", res_ready, 1);
      send_matrix($urandom, 1, 0);
      wait_drain("drain6_timeout");
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_drain.md
# rf_drain

Result-side counterpart of the register file's write port: captures an N×N result matrix shifted out of the systolic array one row-vector per beat, then serialises it as a linear ADDR/DATA word stream with a valid/ready handshake. The word order and addressing are identical to the register-file load order (index = row·N + col), so a drained matrix can be written straight back into the register file or to memory. Sits between the systolic-array result outputs and the write-back path.

## Interface
- N, 8, matrix dimension (rows = columns = N)
- DATA_W, 16, result word width
- ADDR_W, 32, address width
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- BASE_ADDR  in  ADDR_W  word address of element (0,0); sampled on first capture beat
- RES_VALID  in  1  RES_IN holds a valid row
- RES_IN  in  [0:N-1] × DATA_W  one result row, element c = column c
- RES_READY  out  1  block accepts a row this cycle
- OUT_VALID  out  1  OUT_ADDR/OUT_DATA valid
- OUT_READY  in  1  downstream accepts word
- OUT_ADDR  out  ADDR_W  target word address
- OUT_DATA  out  DATA_W  result word
- OUT_LAST  out  1  marks final word (index N·N−1)
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-cycle pulse after final word accepted
- OVF  out  1  sticky: RES_VALID seen while RES_READY low

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: RES_READY=1. On RES_VALID: store RES_IN as row 0, latch BASE_ADDR, row_cnt←1, OVF←0, → CAPTURE.
- CAPTURE: RES_READY=1. Each RES_VALID beat stores row row_cnt, row_cnt+1. Beat with row_cnt=N−1 → DRAIN, idx←0. Gaps (RES_VALID low) allowed, no timeout.
- DRAIN: RES_READY=0, OUT_VALID=1. OUT_DATA=buf[idx/N][idx%N], OUT_ADDR=base+idx (modulo 2^ADDR_W, wrap silent). Advance idx on OUT_VALID&OUT_READY. Handshake at idx=N·N−1 → IDLE, DONE=1 next cycle.
- OUT_ADDR/OUT_DATA/OUT_LAST stable while OUT_VALID&!OUT_READY.
- RES_VALID during DRAIN: row dropped, OVF←1, buffer untouched. OVF cleared only on first beat of next capture or reset.
- Reset (any time, including mid-capture/mid-drain): state IDLE, counters 0, partial matrix discarded, no DONE.
- Reset values: RES_READY=1 (after reset release), OUT_VALID=0, OUT_ADDR=0, OUT_DATA=0, OUT_LAST=0, BUSY=0, DONE=0, OVF=0. Buffer contents need not reset.

## Timing
- Capture: one row per cycle when RES_VALID held; N beats → N cycles.
- Latency: OUT_VALID asserted in cycle immediately after edge accepting row N−1; first word is (0,0).
- Drain throughput: one word per cycle with OUT_READY held high; N·N cycles minimum.
- DONE and RES_READY both high in the cycle after the final OUT handshake; a RES_VALID in that cycle starts a new capture (back-to-back matrices, one idle-free turnaround).
- All outputs registered or decoded from registered state/counters only; no combinational path RES_VALID→OUT_* or OUT_READY→RES_READY.

## Structure
- Shared package systolic_pkg: N, DATA_W, ADDR_W constants, state enum (IDLE/CAPTURE/DRAIN), row-vector typedef (array [0:N-1] of DATA_W).
- Sub-module drain_buf: N×N register storage, row write port (row index + vector), single word read port (linear index). FSM, counters, handshake in rf_drain top.

## Test plan
- Reset, feed rows r with RES_IN[c]=r·8+c, BASE_ADDR=0x100, OUT_READY=1 -> words 0..63 at addresses 0x100..0x13F, OUT_LAST only on word 63, DONE one cycle later.
- Same matrix, OUT_READY toggled pseudo-randomly -> identical 64-word sequence, outputs stable during stalls, no duplicates or drops.
- RES_VALID pulsed during DRAIN -> OVF=1, drained data unchanged; next capture clears OVF.
- BASE_ADDR=0xFFFF_FFF8 -> addresses wrap 0xFFFF_FFF8..0xFFFF_FFFF, 0x0..0x37.
- RST_N asserted at drain word 20 -> OUT_VALID=0, BUSY=0 immediately; new full matrix after release drains from word 0 with no stale data.
- Two matrices back-to-back, RES_VALID high in DONE cycle -> second capture starts that cycle, second stream correct.
